// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss stopwatch.
package stopwatch_pkg;
    typedef enum logic {RUN = 1'b0, PAUSED = 1'b1} run_state_t;

    localparam int DIGIT_W          = 4;
    localparam int SEC_MAX          = 59;
    localparam int MIN_MAX          = 59;
    localparam int TICK_DIV_DEFAULT = 100_000_000;
endpackage

// File: rtl/stopwatch_if.sv
// Control inputs and display outputs of the stopwatch core.
interface stopwatch_if;
    import stopwatch_pkg::*;

    logic               pause_pulse;
    logic               adj;
    logic               sel;
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
    logic               blink;
    logic               running;

    modport master (
        output pause_pulse, adj, sel,
        input  min_tens, min_ones, sec_tens, sec_ones, blink, running
    );
    modport slave (
        input  pause_pulse, adj, sel,
        output min_tens, min_ones, sec_tens, sec_ones, blink, running
    );
endinterface

// File: rtl/stopwatch_bcd_mod60.sv
// Two-digit BCD counter 00..MAX; carry_out is combinational so the next
// field advances on the same edge as the wrap.
module bcd_mod60
    import stopwatch_pkg::*;
#(
    parameter int MAX = SEC_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               carry_en,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               carry_out
);
    localparam logic [DIGIT_W-1:0] MAX_T = DIGIT_W'(MAX / 10);
    localparam logic [DIGIT_W-1:0] MAX_O = DIGIT_W'(MAX % 10);
    localparam logic [DIGIT_W-1:0] NINE  = DIGIT_W'(9);

    logic at_max;

    assign at_max    = (tens == MAX_T) && (ones == MAX_O);
    assign carry_out = inc & carry_en & at_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (at_max) begin
                tens <= '0;
                ones <= '0;
            end else if (ones == NINE) begin
                tens <= tens + 1'b1;
                ones <= '0;
            end else begin
                ones <= ones + 1'b1;
            end
        end
    end
endmodule

// File: rtl/stopwatch_core.sv
// mm:ss stopwatch: free-running tick divider, run/pause FSM, adjust mode
// with blinking field enable, and two BCD mod-60 counters.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    stopwatch_if.slave  sw
);
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] Q1 = DW'(TICK_DIV / 4 - 1);
    localparam logic [DW-1:0] Q2 = DW'(TICK_DIV / 2 - 1);
    localparam logic [DW-1:0] Q3 = DW'(3 * (TICK_DIV / 4) - 1);
    localparam logic [DW-1:0] Q4 = DW'(TICK_DIV - 1);

    logic [DW-1:0] div;
    logic          tick_1, tick_2, tick_4;
    run_state_t    state, state_nxt;
    logic          run_q;
    logic          blink_q;
    logic          sec_inc, min_inc, sec_carry;
    logic          unused_min_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         div <= '0;
        else if (div == Q4) div <= '0;
        else                div <= div + 1'b1;
    end

    assign tick_1 = (div == Q4);
    assign tick_2 = tick_1 | (div == Q2);
    assign tick_4 = tick_2 | (div == Q1) | (div == Q3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (sw.pause_pulse) state_nxt = (state == RUN) ? PAUSED : RUN;
    end

    always_comb begin
        run_q = (state == RUN);
    end

    assign sw.running = run_q;

    // Increments see the registered state, so a coincident pause still counts.
    assign sec_inc = sw.adj ? (tick_2 & ~sw.sel) : (tick_1 & run_q);
    assign min_inc = sw.adj ? (tick_2 &  sw.sel) : sec_carry;

    // Held at 1 outside adjust, so the first adjust cycle always shows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       blink_q <= 1'b1;
        else if (!sw.adj) blink_q <= 1'b1;
        else if (tick_4)  blink_q <= ~blink_q;
    end

    assign sw.blink = ~sw.adj | blink_q;

    bcd_mod60 #(.MAX(SEC_MAX)) u_sec (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (sec_inc),
        .carry_en  (~sw.adj),
        .tens      (sw.sec_tens),
        .ones      (sw.sec_ones),
        .carry_out (sec_carry)
    );

    bcd_mod60 #(.MAX(MIN_MAX)) u_min (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (min_inc),
        .carry_en  (1'b0),
        .tens      (sw.min_tens),
        .ones      (sw.min_ones),
        .carry_out (unused_min_carry)
    );
endmodule

// File: tb/tb_stopwatch_core.sv
// Scenario bench for stopwatch_core with TICK_DIV=8.
module tb_stopwatch_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n = 0;
    logic [15:0] exp_q[$];
    logic [15:0] dig;
    logic [15:0] e;

    stopwatch_if sw();

    stopwatch_core #(.TICK_DIV(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw)
    );

    assign dig = {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};

    always #5 clk = ~clk;

    task automatic step(input int k);
        repeat (k) @(negedge clk);
        n += k;
    endtask

    task automatic go(input int t);
        if (t > n) step(t - n);
    endtask

    // Reset and release on a falling edge; n counts rising edges since release.
    task automatic rel();
        @(negedge clk);
        rst_n = 1'b0;
        sw.pause_pulse = 1'b0;
        sw.adj = 1'b0;
        sw.sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw.pause_pulse = 1'b0;
        sw.adj = 1'b0;
        sw.sel = 1'b0;
        #3;
        checks++;
        if (dig !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h expected 0000", dig); end
        checks++;
        if (sw.running !== 1'b1) begin errors++; $display("FAIL reset_running: got %b expected 1", sw.running); end
        checks++;
        if (sw.blink !== 1'b1) begin errors++; $display("FAIL reset_blink: got %b expected 1", sw.blink); end
    endtask

    task automatic test_count();
        rel();
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0010);
        go(7);
        e = exp_q.pop_front(); checks++;
        if (dig !== e) begin errors++; $display("FAIL count_before_tick: got %h expected %h", dig, e); end
        go(8);
        e = exp_q.pop_front(); checks++;
        if (dig !== e) begin errors++; $display("FAIL count_first_tick: got %h expected %h", dig, e); end
        go(80);
        e = exp_q.pop_front(); checks++;
        if (dig !== e) begin errors++; $display("FAIL count_ten_sec: got %h expected %h", dig, e); end
    endtask

    task automatic test_adjust_sec();
        rel();
        sw.adj = 1'b1;
        sw.sel = 1'b0;
        #1;
        checks++;
        if (sw.blink !== 1'b1) begin errors++; $display("FAIL adj_blink_first: got %b expected 1", sw.blink); end
        go(2); #1;
        checks++;
        if (sw.blink !== 1'b0) begin errors++; $display("FAIL adj_blink_n2: got %b expected 0", sw.blink); end
        go(4); #1;
        checks++;
        if (sw.blink !== 1'b1) begin errors++; $display("FAIL adj_blink_n4: got %b expected 1", sw.blink); end
        exp_q.push_back(16'h0058);
        exp_q.push_back(16'h0059);
        exp_q.push_back(16'h0000);
        go(232);
        e = exp_q.pop_front(); checks++;
        if (dig !== e) begin errors++; $display("FAIL adj_sec_58: got %h expected %h", dig, e); end
        go(236);
        e = exp_q.pop_front(); checks++;
        if (dig !== e) begin errors++; $display("FAIL adj_sec_59: got %h expected %h", dig, e); end
        go(240);
        e = exp_q.pop_front(); checks++;
        if (dig !== e) begin errors++; $display("FAIL adj_sec_wrap: got %h expected %h", dig, e); end
        sw.adj = 1'b0;
        #1;
        checks++;
        if (sw.blink !== 1'b1) begin errors++; $display("FAIL adj_exit_blink: got %b expected 1", sw.blink); end
    endtask

    task automatic test_wrap();
        rel();
        sw.adj = 1'b1;
        sw.sel = 1'b0;
        exp_q.push_back(16'h5959);
        exp_q.push_back(16'h5959);
        exp_q.push_back(16'h0000);
        go(236);
        sw.sel = 1'b1;
        go(472);
        e = exp_q.pop_front(); checks++;
        if (dig !== e) begin errors++; $display("FAIL wrap_preload: got %h expected %h", dig, e); end
        sw.adj = 1'b0;
        go(479);
        e = exp_q.pop_front(); checks++;
        if (dig !== e) begin errors++; $display("FAIL wrap_before_tick: got %h expected %h", dig, e); end
        go(480);
        e = exp_q.pop_front(); checks++;
        if (dig !== e) begin errors++; $display("FAIL wrap_rollover: got %h expected %h", dig, e); end
    endtask

    task automatic test_pause();
        rel();
        exp_q.push_back(16'h0003);
        exp_q.push_back(16'h0003);
        exp_q.push_back(16'h0004);
        go(24);
        sw.pause_pulse = 1'b1;
        step(1);
        sw.pause_pulse = 1'b0;
        checks++;
        if (sw.running !== 1'b0) begin errors++; $display("FAIL pause_running: got %b expected 0", sw.running); end
        go(65);
        e = exp_q.pop_front(); checks++;
        if (dig !== e) begin errors++; $display("FAIL pause_hold: got %h expected %h", dig, e); end
        sw.pause_pulse = 1'b1;
        step(1);
        sw.pause_pulse = 1'b0;
        go(71);
        e = exp_q.pop_front(); checks++;
        if (dig !== e) begin errors++; $display("FAIL resume_before_tick: got %h expected %h", dig, e); end
        go(72);
        e = exp_q.pop_front(); checks++;
        if (dig !== e) begin errors++; $display("FAIL resume_tick: got %h expected %h", dig, e); end
        checks++;
        if (sw.running !== 1'b1) begin errors++; $display("FAIL resume_running: got %b expected 1", sw.running); end
    endtask

    task automatic test_coincident();
        rel();
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0001);
        go(7);
        sw.pause_pulse = 1'b1;
        step(1);
        sw.pause_pulse = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (dig !== e) begin errors++; $display("FAIL coinc_increment: got %h expected %h", dig, e); end
        checks++;
        if (sw.running !== 1'b0) begin errors++; $display("FAIL coinc_running: got %b expected 0", sw.running); end
        go(16);
        e = exp_q.pop_front(); checks++;
        if (dig !== e) begin errors++; $display("FAIL coinc_hold: got %h expected %h", dig, e); end
    endtask

    task automatic test_async_reset();
        rel();
        sw.adj = 1'b1;
        sw.sel = 1'b0;
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h0000);
        go(136);
        sw.sel = 1'b1;
        go(184);
        e = exp_q.pop_front(); checks++;
        if (dig !== e) begin errors++; $display("FAIL areset_preload: got %h expected %h", dig, e); end
        sw.adj = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        e = exp_q.pop_front(); checks++;
        if (dig !== e) begin errors++; $display("FAIL areset_digits: got %h expected %h", dig, e); end
        checks++;
        if (sw.running !== 1'b1) begin errors++; $display("FAIL areset_running: got %b expected 1", sw.running); end
        checks++;
        if (sw.blink !== 1'b1) begin errors++; $display("FAIL areset_blink: got %b expected 1", sw.blink); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_count();
        test_adjust_sec();
        test_wrap();
        test_pause();
        test_coincident();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter TICK_DIV, default 100_000_000, means clock cycles per 1 Hz tick; it SHALL be a multiple of 4 and at least 8.
REQ-002 Port clk, input, 1 bit: sole clock, rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Port pause_pulse, input, 1 bit: single-cycle pulse from the upstream button debouncer; toggles run/pause.
REQ-005 Port adj, input, 1 bit: adjust mode when 1.
REQ-006 Port sel, input, 1 bit: field selected for adjust; 0 = seconds, 1 = minutes.
REQ-007 Port min_tens, min_ones, sec_tens, sec_ones, output, 4 bits each: BCD digits to the display driver.
REQ-008 Port blink, output, 1 bit: display-enable for the selected field; 1 = show.
REQ-009 Port running, output, 1 bit: 1 in RUN, 0 in PAUSED.

Function
REQ-010 A free-running divider SHALL count 0..TICK_DIV-1 and wrap; it is never cleared except by reset.
REQ-011 tick_1 SHALL assert for one cycle when the divider equals TICK_DIV-1.
REQ-012 tick_2 SHALL assert for one cycle when the divider equals TICK_DIV/2-1 or TICK_DIV-1.
REQ-013 tick_4 SHALL assert for one cycle at each divider value k*TICK_DIV/4-1, k = 1..4.
REQ-014 The run state machine SHALL have two states, RUN and PAUSED; pause_pulse SHALL toggle the state in every mode, including while adj=1.
REQ-015 With adj=0 and state RUN, each tick_1 SHALL increment the time by one second.
REQ-016 Seconds 59 SHALL wrap to 00 and carry into minutes; 59:59 SHALL wrap to 00:00 with no flag.
REQ-017 With adj=0 and state PAUSED, all digits SHALL hold.
REQ-018 With adj=1, normal counting SHALL stop; each tick_2 SHALL increment only the field chosen by sel.
REQ-019 In adjust, that field SHALL wrap 59 to 00 with no carry into the other field; this applies in RUN and PAUSED alike.
REQ-020 All digit outputs SHALL be registered and SHALL change on the clock edge that samples the tick (latency 1 cycle from the tick).
REQ-021 When pause_pulse and tick_1 occur in the same cycle, the increment SHALL use the pre-toggle state; the toggle takes effect for the next tick.
REQ-022 sel or adj changes SHALL take effect at the next tick; no partial or double increment is permitted.
REQ-023 blink SHALL be constant 1 when adj=0.
REQ-024 When adj=1, blink SHALL toggle on each tick_4.
REQ-025 On a 0-to-1 edge of adj, blink SHALL be set to 1 in the first adjust cycle.

Reset
REQ-026 While rst_n=0, all outputs and state SHALL be forced asynchronously: digits 0, divider 0, state RUN, running=1, blink=1.
REQ-027 Deassertion mid-operation SHALL restart from 00:00; the first tick_1 SHALL occur TICK_DIV cycles after release.
REQ-028 rst_n is synchronised to clk by the top level before it reaches this block.

Structure
REQ-029 Shared package stopwatch_pkg SHALL hold:
- the run-state encoding (RUN, PAUSED);
- the BCD digit width (4);
- the constants SEC_MAX=59 and MIN_MAX=59;
- the default TICK_DIV.
REQ-030 One sub-module, bcd_mod60: a two-digit BCD 00..59 counter.
- Inputs: clk, rst_n, inc, carry_en.
- Outputs: tens, ones, carry_out.
- carry_out asserts when inc=1 at 59 with carry_en=1.
- Instantiated twice, once for seconds and once for minutes.

Verification (TICK_DIV=8)
REQ-031 Reset release, adj=0 -> after 8 cycles sec_ones=1; after 80 cycles time=00:10.
REQ-032 Preload to 59:59 via adjust, then run one tick_1 -> 00:00 one cycle after the tick.
REQ-033 pause_pulse at 00:03 -> running=0 and digits hold for 40 cycles; second pulse -> counting resumes at the next tick_1.
REQ-034 adj=1, sel=0 from 00:58 -> 00:59 then 00:00 on successive tick_2 (every 4 cycles), minutes unchanged; blink toggles every 2 cycles.
REQ-035 pause_pulse coincident with tick_1 in RUN -> the increment occurs and running=0 next cycle.
REQ-036 rst_n low mid-count at 12:34 -> outputs 00:00 immediately, without waiting for a clock edge.
